// File: rtl/beam_trigger_scaler.sv
// Per-beam trigger rate scaler: holdoff-qualified triggers are counted over a programmable
// window of aclk cycles, then snapshotted for readout. Supports single-shot or continuous runs.
module beam_trigger_scaler #(
    parameter int NBEAMS       = 2,
    parameter int COUNT_BITS   = 32,
    parameter int PERIOD_BITS  = 32,
    parameter int HOLDOFF_BITS = 8,
    localparam int SEL_BITS    = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                    aclk,
    input  logic                    reset_i,
    input  logic [NBEAMS-1:0]       trig_i,
    input  logic [PERIOD_BITS-1:0]  period_i,
    input  logic [HOLDOFF_BITS-1:0] holdoff_i,
    input  logic                    continuous_i,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic [SEL_BITS-1:0]     rd_sel_i,
    output logic [NBEAMS-1:0]       trigger_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    valid_o,
    output logic [COUNT_BITS-1:0]   rd_count_o,
    output logic                    rd_sat_o,
    output logic [15:0]             windows_o
);

    localparam logic [COUNT_BITS-1:0]   CNT_ONE  = 1;
    localparam logic [PERIOD_BITS-1:0]  PER_ONE  = 1;
    localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE = 1;

    typedef enum logic {ST_IDLE, ST_COUNT} state_t;

    state_t                  state, state_next;
    logic                    load, terminal;
    logic [PERIOD_BITS-1:0]  timer, period_sh;
    logic [HOLDOFF_BITS-1:0] holdoff_sh;
    logic                    cont_sh;

    logic [HOLDOFF_BITS-1:0] hold    [NBEAMS];
    logic [COUNT_BITS-1:0]   cnt     [NBEAMS];
    logic [COUNT_BITS-1:0]   cnt_inc [NBEAMS];
    logic [COUNT_BITS-1:0]   snap    [NBEAMS];
    logic [NBEAMS-1:0]       q, cnt_full, sat, sat_next, snap_sat;

    // A zero period behaves as a one-cycle window.
    function automatic logic [PERIOD_BITS-1:0] reload_of(input logic [PERIOD_BITS-1:0] p);
        return (p == '0) ? '0 : p - PER_ONE;
    endfunction

    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            q[b]        = trig_i[b] && (hold[b] == '0);
            cnt_full[b] = &cnt[b];
            cnt_inc[b]  = (q[b] && !cnt_full[b]) ? cnt[b] + CNT_ONE : cnt[b];
            sat_next[b] = sat[b] | (q[b] & cnt_full[b]);
        end
    end

    // Stop beats start; a start on the terminal cycle restarts without a snapshot.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        terminal   = 1'b0;
        if (stop_i) begin
            state_next = ST_IDLE;
        end else if (start_i) begin
            state_next = ST_COUNT;
            load       = 1'b1;
        end else if (state == ST_COUNT && timer == '0) begin
            terminal = 1'b1;
            if (!cont_sh) state_next = ST_IDLE;
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) state <= ST_IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            timer      <= '0;
            period_sh  <= '0;
            holdoff_sh <= '0;
            cont_sh    <= 1'b0;
            sat        <= '0;
            snap_sat   <= '0;
            trigger_o  <= '0;
            done_o     <= 1'b0;
            valid_o    <= 1'b0;
            windows_o  <= '0;
            for (int b = 0; b < NBEAMS; b++) begin
                hold[b] <= '0;
                cnt[b]  <= '0;
                snap[b] <= '0;
            end
        end else begin
            trigger_o <= q;
            done_o    <= terminal;
            if (terminal) windows_o <= windows_o + 16'd1;
            if (load)          valid_o <= 1'b0;
            else if (terminal) valid_o <= 1'b1;

            for (int b = 0; b < NBEAMS; b++) begin
                if (load)                hold[b] <= '0;
                else if (q[b])           hold[b] <= holdoff_sh;
                else if (hold[b] != '0)  hold[b] <= hold[b] - HOLD_ONE;
            end

            if (load) begin
                period_sh  <= period_i;
                holdoff_sh <= holdoff_i;
                cont_sh    <= continuous_i;
                timer      <= reload_of(period_i);
                sat        <= '0;
                for (int b = 0; b < NBEAMS; b++) cnt[b] <= '0;
            end else if (state == ST_COUNT) begin
                if (terminal) begin
                    timer    <= reload_of(period_sh);
                    snap_sat <= sat_next;
                    sat      <= '0;
                    for (int b = 0; b < NBEAMS; b++) begin
                        snap[b] <= cnt_inc[b];
                        cnt[b]  <= '0;
                    end
                end else begin
                    timer <= timer - PER_ONE;
                    sat   <= sat_next;
                    for (int b = 0; b < NBEAMS; b++) cnt[b] <= cnt_inc[b];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            rd_count_o <= '0;
            rd_sat_o   <= 1'b0;
        end else if (int'(rd_sel_i) < NBEAMS) begin
            rd_count_o <= snap[rd_sel_i];
            rd_sat_o   <= snap_sat[rd_sel_i];
        end else begin
            rd_count_o <= '0;
            rd_sat_o   <= 1'b0;
        end
    end

    assign busy_o = (state == ST_COUNT);

endmodule

// File: tb/tb_beam_trigger_scaler.sv
// Directed bench for beam_trigger_scaler: default instance plus a 4-bit-counter instance
// for saturation and a 3-beam instance for out-of-range readout select.
module tb_beam_trigger_scaler;

    logic        aclk = 1'b0;
    logic        reset_i;
    logic [1:0]  trig_i;
    logic [31:0] period_i;
    logic [7:0]  holdoff_i;
    logic        continuous_i, start_i, stop_i;
    logic        rd_sel_i;
    logic [1:0]  rd_sel3;

    logic [1:0]  trigger_o;
    logic        busy_o, done_o, valid_o, rd_sat_o;
    logic [31:0] rd_count_o;
    logic [15:0] windows_o;

    logic [1:0]  trigger4;
    logic        busy4, done4, valid4, rd_sat4;
    logic [3:0]  rd_count4;
    logic [15:0] windows4;

    logic [2:0]  trig3;
    logic [2:0]  trigger3;
    logic        busy3, done3, valid3, rd_sat3;
    logic [31:0] rd_count3;
    logic [15:0] windows3;

    int errors = 0;
    int checks = 0;

    assign trig3 = {trig_i[0], trig_i};

    always #5 aclk = ~aclk;

    beam_trigger_scaler dut (
        .aclk(aclk), .reset_i(reset_i), .trig_i(trig_i), .period_i(period_i),
        .holdoff_i(holdoff_i), .continuous_i(continuous_i), .start_i(start_i),
        .stop_i(stop_i), .rd_sel_i(rd_sel_i), .trigger_o(trigger_o), .busy_o(busy_o),
        .done_o(done_o), .valid_o(valid_o), .rd_count_o(rd_count_o), .rd_sat_o(rd_sat_o),
        .windows_o(windows_o)
    );

    beam_trigger_scaler #(.COUNT_BITS(4)) dut4 (
        .aclk(aclk), .reset_i(reset_i), .trig_i(trig_i), .period_i(period_i),
        .holdoff_i(holdoff_i), .continuous_i(continuous_i), .start_i(start_i),
        .stop_i(stop_i), .rd_sel_i(rd_sel_i), .trigger_o(trigger4), .busy_o(busy4),
        .done_o(done4), .valid_o(valid4), .rd_count_o(rd_count4), .rd_sat_o(rd_sat4),
        .windows_o(windows4)
    );

    beam_trigger_scaler #(.NBEAMS(3)) dut3 (
        .aclk(aclk), .reset_i(reset_i), .trig_i(trig3), .period_i(period_i),
        .holdoff_i(holdoff_i), .continuous_i(continuous_i), .start_i(start_i),
        .stop_i(stop_i), .rd_sel_i(rd_sel3), .trigger_o(trigger3), .busy_o(busy3),
        .done_o(done3), .valid_o(valid3), .rd_count_o(rd_count3), .rd_sat_o(rd_sat3),
        .windows_o(windows3)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (trigger_o !== 2'b00) begin errors++; $display("FAIL reset_trigger: got %b want 00", trigger_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (rd_count_o !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", rd_count_o); end
        checks++; if (windows_o !== 16'd0) begin errors++; $display("FAIL reset_windows: got %0d want 0", windows_o); end
    endtask

    task automatic test_single();
        trig_i = 2'b01; period_i = 32'd10; holdoff_i = 8'd0; continuous_i = 1'b0; rd_sel_i = 1'b0;
        pulse_start();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_start: got %b want 1", busy_o); end
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (done_o !== (i == 10)) begin errors++; $display("FAIL t1_done i=%0d: got %b want %b", i, done_o, i == 10); end
            checks++; if (busy_o !== (i < 10)) begin errors++; $display("FAIL t1_busy i=%0d: got %b want %b", i, busy_o, i < 10); end
        end
        trig_i = 2'b00;
        tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b want 0", done_o); end
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", valid_o); end
        checks++; if (rd_count_o !== 32'd10) begin errors++; $display("FAIL t1_count0: got %0d want 10", rd_count_o); end
        checks++; if (windows_o !== 16'd1) begin errors++; $display("FAIL t1_windows: got %0d want 1", windows_o); end
        rd_sel_i = 1'b1;
        tick();
        checks++; if (rd_count_o !== 32'd0) begin errors++; $display("FAIL t1_count1: got %0d want 0", rd_count_o); end
    endtask

    task automatic test_holdoff();
        trig_i = 2'b01; period_i = 32'd20; holdoff_i = 8'd3; rd_sel_i = 1'b0;
        pulse_start();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL t2_valid_clear: got %b want 0", valid_o); end
        for (int i = 1; i <= 20; i++) begin
            tick();
            checks++; if (trigger_o[0] !== (i % 4 == 1)) begin errors++; $display("FAIL t2_trigger i=%0d: got %b want %b", i, trigger_o[0], i % 4 == 1); end
        end
        trig_i = 2'b00;
        tick();
        checks++; if (rd_count_o !== 32'd5) begin errors++; $display("FAIL t2_count0: got %0d want 5", rd_count_o); end
        checks++; if (windows_o !== 16'd2) begin errors++; $display("FAIL t2_windows: got %0d want 2", windows_o); end
    endtask

    task automatic test_continuous();
        do_reset();
        trig_i = 2'b00; period_i = 32'd8; holdoff_i = 8'd0; continuous_i = 1'b1; rd_sel_i = 1'b1;
        pulse_start();
        continuous_i = 1'b0;
        trig_i = 2'b10;
        for (int i = 1; i <= 25; i++) begin
            tick();
            trig_i[1] = ~trig_i[1];
            checks++; if (done_o !== (i % 8 == 0)) begin errors++; $display("FAIL t3_done i=%0d: got %b want %b", i, done_o, i % 8 == 0); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t3_busy i=%0d: got %b want 1", i, busy_o); end
            if (i % 8 == 0) begin
                checks++; if (windows_o !== 16'(i / 8)) begin errors++; $display("FAIL t3_windows i=%0d: got %0d want %0d", i, windows_o, i / 8); end
            end
            if (i > 8 && i % 8 == 1) begin
                checks++; if (rd_count_o !== 32'd4) begin errors++; $display("FAIL t3_count1 i=%0d: got %0d want 4", i, rd_count_o); end
            end
        end
        trig_i = 2'b00;
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t3_stop_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_saturation();
        trig_i = 2'b01; period_i = 32'd20; holdoff_i = 8'd0; continuous_i = 1'b0; rd_sel_i = 1'b0;
        pulse_start();
        repeat (21) tick();
        checks++; if (rd_count4 !== 4'd15) begin errors++; $display("FAIL t4_sat_count: got %0d want 15", rd_count4); end
        checks++; if (rd_sat4 !== 1'b1) begin errors++; $display("FAIL t4_sat_flag: got %b want 1", rd_sat4); end
        checks++; if (rd_count_o !== 32'd20) begin errors++; $display("FAIL t4_wide_count: got %0d want 20", rd_count_o); end
        checks++; if (rd_sat_o !== 1'b0) begin errors++; $display("FAIL t4_wide_sat: got %b want 0", rd_sat_o); end
        period_i = 32'd15;
        pulse_start();
        repeat (16) tick();
        checks++; if (rd_count4 !== 4'd15) begin errors++; $display("FAIL t4_full_count: got %0d want 15", rd_count4); end
        checks++; if (rd_sat4 !== 1'b0) begin errors++; $display("FAIL t4_full_sat: got %b want 0", rd_sat4); end
        checks++; if (rd_count_o !== 32'd15) begin errors++; $display("FAIL t4_wide_count15: got %0d want 15", rd_count_o); end
    endtask

    task automatic test_stop();
        trig_i = 2'b01; period_i = 32'd10; rd_sel_i = 1'b0;
        pulse_start();
        repeat (5) tick();
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_stop_busy: got %b want 0", busy_o); end
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t5_no_done i=%0d: got %b want 0", i, done_o); end
        end
        checks++; if (rd_count_o !== 32'd15) begin errors++; $display("FAIL t5_snap_kept: got %0d want 15", rd_count_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL t5_valid: got %b want 0", valid_o); end
        pulse_start();
        repeat (2) tick();
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_startstop_count: got %b want 0", busy_o); end
        start_i = 1'b1; stop_i = 1'b1;
        tick();
        start_i = 1'b0; stop_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t5_startstop_idle: got %b want 0", busy_o); end
        period_i = 32'd4;
        pulse_start();
        repeat (3) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t5_restart_done: got %b want 0", done_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t5_restart_busy: got %b want 1", busy_o); end
        checks++; if (windows_o !== 16'd5) begin errors++; $display("FAIL t5_restart_windows: got %0d want 5", windows_o); end
        repeat (3) tick();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL t5_early_done: got %b want 0", done_o); end
        tick();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL t5_second_done: got %b want 1", done_o); end
        checks++; if (windows_o !== 16'd6) begin errors++; $display("FAIL t5_second_windows: got %0d want 6", windows_o); end
        tick();
        checks++; if (rd_count_o !== 32'd4) begin errors++; $display("FAIL t5_second_count: got %0d want 4", rd_count_o); end
    endtask

    task automatic test_reset_mid();
        trig_i = 2'b11; period_i = 32'd100;
        pulse_start();
        repeat (5) tick();
        reset_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t6_busy: got %b want 0", busy_o); end
        checks++; if (trigger_o !== 2'b00) begin errors++; $display("FAIL t6_trigger: got %b want 00", trigger_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL t6_valid: got %b want 0", valid_o); end
        checks++; if (windows_o !== 16'd0) begin errors++; $display("FAIL t6_windows: got %0d want 0", windows_o); end
        checks++; if (rd_count_o !== 32'd0) begin errors++; $display("FAIL t6_count: got %0d want 0", rd_count_o); end
        tick();
        reset_i = 1'b0;
        tick();
        trig_i = 2'b01; period_i = 32'd6; rd_sel3 = 2'd2;
        pulse_start();
        repeat (7) tick();
        checks++; if (rd_count3 !== 32'd6) begin errors++; $display("FAIL t6_sel_last: got %0d want 6", rd_count3); end
        rd_sel3 = 2'd3;
        tick();
        checks++; if (rd_count3 !== 32'd0) begin errors++; $display("FAIL t6_sel_oob: got %0d want 0", rd_count3); end
        checks++; if (rd_sat3 !== 1'b0) begin errors++; $display("FAIL t6_sel_oob_sat: got %b want 0", rd_sat3); end
    endtask

    initial begin
        reset_i = 1'b1; trig_i = 2'b00; period_i = 32'd0; holdoff_i = 8'd0;
        continuous_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; rd_sel_i = 1'b0; rd_sel3 = 2'd0;
        test_reset();
        test_single();
        test_holdoff();
        test_continuous();
        test_saturation();
        test_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
